// File: rtl/fft_frame_scheduler.sv
// CORDIC FFT frame scheduler: issues one unbroken pair burst per frame, enforces the
// valid-low gap between bursts and tracks frames in flight through the pipeline.
module fft_frame_scheduler #(
  parameter int PAIRS_PER_FRAME = 512,
  parameter int CNT_W           = 10,
  parameter int GAP_CYCLES      = 1,
  parameter int MAX_INFLIGHT    = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic [CNT_W:0]   i_src_level,
  output logic             o_src_rd,
  output logic             o_pipe_valid,
  output logic             o_frame_start,
  input  logic             i_out_valid,
  output logic             o_frame_done,
  output logic [1:0]       o_inflight,
  output logic [15:0]      o_frames_done,
  output logic             o_busy,
  output logic             o_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BURST = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] BURST_LAST   = CNT_W'(PAIRS_PER_FRAME - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W:0]   LEVEL_MIN    = (CNT_W+1)'(PAIRS_PER_FRAME);
  localparam logic [1:0]       INFLIGHT_MAX = 2'(MAX_INFLIGHT);

  logic [1:0]       state_r;
  logic [1:0]       state_nxt_s;
  logic [CNT_W-1:0] burst_cnt_r;
  logic [CNT_W-1:0] burst_cnt_nxt_s;
  logic [CNT_W-1:0] gap_cnt_r;
  logic [CNT_W-1:0] gap_cnt_nxt_s;
  logic [CNT_W-1:0] out_cnt_r;
  logic [CNT_W-1:0] out_cnt_nxt_s;
  logic [1:0]       inflight_r;
  logic [1:0]       inflight_nxt_s;
  logic             start_s;
  logic             out_hit_s;
  logic             done_s;
  logic             busy_nxt_s;
  logic             pipe_valid_r;
  logic             frame_start_r;
  logic             frame_done_r;
  logic             busy_r;
  logic             err_r;
  logic [15:0]      frames_done_r;

  // Frame sequencer: start qualification, burst length and gap length.
  always_comb begin
    state_nxt_s     = state_r;
    burst_cnt_nxt_s = burst_cnt_r;
    gap_cnt_nxt_s   = gap_cnt_r;
    start_s         = 1'b0;
    case (state_r)
      IDLE: begin
        if (i_enable && (i_src_level >= LEVEL_MIN) && (inflight_r < INFLIGHT_MAX)) begin
          start_s         = 1'b1;
          state_nxt_s     = BURST;
          burst_cnt_nxt_s = CNT_ZERO;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        if (burst_cnt_r == BURST_LAST) begin
          state_nxt_s   = GAP;
          gap_cnt_nxt_s = CNT_ZERO;
        end else begin
          burst_cnt_nxt_s = burst_cnt_r + CNT_ONE;
        end
      end
      GAP: begin
        if (gap_cnt_r == GAP_LAST) begin
          state_nxt_s = IDLE;
        end else begin
          gap_cnt_nxt_s = gap_cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Output-side frame tracking; a start and a completion in one cycle cancel out.
  always_comb begin
    out_hit_s = i_out_valid && (inflight_r != 2'd0);
    done_s    = out_hit_s && (out_cnt_r == BURST_LAST);
    if (done_s) begin
      out_cnt_nxt_s = CNT_ZERO;
    end else if (out_hit_s) begin
      out_cnt_nxt_s = out_cnt_r + CNT_ONE;
    end else begin
      out_cnt_nxt_s = out_cnt_r;
    end
    case ({start_s, done_s})
      2'b10:   inflight_nxt_s = inflight_r + 2'd1;
      2'b01:   inflight_nxt_s = inflight_r - 2'd1;
      default: inflight_nxt_s = inflight_r;
    endcase
    busy_nxt_s = (state_nxt_s != IDLE) || (inflight_nxt_s != 2'd0);
  end

  // State, counters and registered status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r       <= IDLE;
      burst_cnt_r   <= CNT_ZERO;
      gap_cnt_r     <= CNT_ZERO;
      out_cnt_r     <= CNT_ZERO;
      inflight_r    <= 2'd0;
      pipe_valid_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_done_r  <= 1'b0;
      frames_done_r <= 16'd0;
      busy_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      burst_cnt_r   <= burst_cnt_nxt_s;
      gap_cnt_r     <= gap_cnt_nxt_s;
      out_cnt_r     <= out_cnt_nxt_s;
      inflight_r    <= inflight_nxt_s;
      pipe_valid_r  <= (state_r == BURST);
      frame_start_r <= (state_r == BURST) && (burst_cnt_r == CNT_ZERO);
      frame_done_r  <= done_s;
      busy_r        <= busy_nxt_s;
      if (done_s) begin
        frames_done_r <= frames_done_r + 16'd1;
      end
      if (i_out_valid && (inflight_r == 2'd0)) begin
        err_r <= 1'b1;
      end
    end
  end

  // FIFO pop is a pure decode of the registered state so reset kills it at once.
  assign o_src_rd      = (state_r == BURST);
  assign o_pipe_valid  = pipe_valid_r;
  assign o_frame_start = frame_start_r;
  assign o_frame_done  = frame_done_r;
  assign o_inflight    = inflight_r;
  assign o_frames_done = frames_done_r;
  assign o_busy        = busy_r;
  assign o_err         = err_r;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler with PAIRS_PER_FRAME=8, GAP_CYCLES=2, MAX_INFLIGHT=2.
module tb_fft_frame_scheduler;

  localparam int CW = 10;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_enable;
  logic [CW:0]   i_src_level;
  logic          i_out_valid;
  logic          o_src_rd;
  logic          o_pipe_valid;
  logic          o_frame_start;
  logic          o_frame_done;
  logic [1:0]    o_inflight;
  logic [15:0]   o_frames_done;
  logic          o_busy;
  logic          o_err;

  fft_frame_scheduler #(
    .PAIRS_PER_FRAME(8),
    .CNT_W(CW),
    .GAP_CYCLES(2),
    .MAX_INFLIGHT(2)
  ) dut (
    .i_clk(i_clk),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_src_level(i_src_level),
    .o_src_rd(o_src_rd),
    .o_pipe_valid(o_pipe_valid),
    .o_frame_start(o_frame_start),
    .i_out_valid(i_out_valid),
    .o_frame_done(o_frame_done),
    .o_inflight(o_inflight),
    .o_frames_done(o_frames_done),
    .o_busy(o_busy),
    .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rd;
    logic        pv;
    logic        fs;
    logic [1:0]  inf;
    logic        busy;
    logic        fd;
    logic [15:0] nfd;
    logic        err;
  } exp_t;

  typedef struct {
    logic        en;
    logic [CW:0] lvl;
    logic        ov;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[20];
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t mk(input logic rd, input logic pv, input logic fs,
                              input logic [1:0] inf, input logic busy, input logic fd,
                              input logic [15:0] nfd, input logic err);
    exp_t e;
    e.rd = rd; e.pv = pv; e.fs = fs; e.inf = inf;
    e.busy = busy; e.fd = fd; e.nfd = nfd; e.err = err;
    return e;
  endfunction

  task automatic cmp(input exp_t e, input string tag, input int idx);
    total++;
    if (o_src_rd !== e.rd || o_pipe_valid !== e.pv || o_frame_start !== e.fs ||
        o_inflight !== e.inf || o_busy !== e.busy || o_frame_done !== e.fd ||
        o_frames_done !== e.nfd || o_err !== e.err) begin
      bad++;
      $display("FAIL %s[%0d]: got rd=%b pv=%b fs=%b inf=%0d busy=%b fd=%b nfd=%0d err=%b, want rd=%b pv=%b fs=%b inf=%0d busy=%b fd=%b nfd=%0d err=%b",
               tag, idx, o_src_rd, o_pipe_valid, o_frame_start, o_inflight, o_busy,
               o_frame_done, o_frames_done, o_err, e.rd, e.pv, e.fs, e.inf, e.busy,
               e.fd, e.nfd, e.err);
    end
  endtask

  // Drive one cycle of inputs, queue its expected effect, compare after the edge.
  task automatic step(input logic en, input logic [CW:0] lvl, input logic ov,
                      input exp_t e, input string tag, input int idx);
    exp_t want;
    i_enable    = en;
    i_src_level = lvl;
    i_out_valid = ov;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    want = sb_q.pop_front();
    cmp(want, tag, idx);
  endtask

  // Asynchronous reset applied between edges; every output must clear at once.
  task automatic rst_chk(input string tag);
    i_reset = 1'b1;
    #1;
    cmp(mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0), tag, 0);
    i_enable    = 1'b0;
    i_out_valid = 1'b0;
    i_src_level = '0;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
  endtask

  initial begin
    // single burst then drain of its 8 output pairs
    for (int c = 0; c < 20; c++) begin
      tbl[c].en  = (c == 0);
      tbl[c].lvl = 11'd8;
      tbl[c].ov  = (c >= 11) && (c <= 18);
      tbl[c].e   = mk(c <= 7, (c >= 1) && (c <= 8), c == 1,
                      (c >= 18) ? 2'd0 : 2'd1, c < 18, c == 18,
                      (c >= 18) ? 16'd1 : 16'd0, 1'b0);
    end

    i_reset     = 1'b0;
    i_enable    = 1'b0;
    i_src_level = '0;
    i_out_valid = 1'b0;
    #1;

    rst_chk("reset_a");
    for (int c = 0; c < 20; c++) begin
      step(tbl[c].en, tbl[c].lvl, tbl[c].ov, tbl[c].e, "single_frame", c);
    end

    // level one short of a frame, then exactly a frame, then reset mid-burst
    rst_chk("reset_b");
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 11'd7, 1'b0, mk(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0, 1'b0),
           "level_short", c);
    end
    step(1'b1, 11'd8, 1'b0, mk(1'b1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b0, 16'd0, 1'b0), "level_ok", 20);
    step(1'b0, 11'd8, 1'b0, mk(1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 16'd0, 1'b0), "level_ok", 21);
    step(1'b0, 11'd8, 1'b0, mk(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 16'd0, 1'b0), "level_ok", 22);
    rst_chk("reset_mid_burst");

    // back-to-back bursts, inflight limit, release by frame completion
    rst_chk("reset_c");
    for (int c = 0; c <= 34; c++) begin
      step(1'b1, 11'd24, (c >= 25) && (c <= 32),
           mk(((c <= 7) || ((c >= 11) && (c <= 18)) || (c >= 33)),
              (((c >= 1) && (c <= 8)) || ((c >= 12) && (c <= 19)) || (c >= 34)),
              ((c == 1) || (c == 12) || (c == 34)),
              (c < 11) ? 2'd1 : ((c == 32) ? 2'd1 : 2'd2),
              1'b1, c == 32, (c >= 32) ? 16'd1 : 16'd0, 1'b0),
           "inflight_limit", c);
    end

    // completion coincident with a start, then enable dropped mid-burst
    rst_chk("reset_d");
    for (int c = 0; c <= 32; c++) begin
      step((c == 0) || ((c >= 12) && (c <= 14)), 11'd8,
           ((c >= 2) && (c <= 8)) || (c == 12) || ((c >= 24) && (c <= 31)),
           mk(((c <= 7) || ((c >= 12) && (c <= 19))),
              (((c >= 1) && (c <= 8)) || ((c >= 13) && (c <= 20))),
              ((c == 1) || (c == 13)),
              (c < 31) ? 2'd1 : 2'd0, c < 31, (c == 12) || (c == 31),
              (c < 12) ? 16'd0 : ((c < 31) ? 16'd1 : 16'd2), 1'b0),
           "start_and_done", c);
    end

    // stray output pair with nothing in flight sets the sticky error only
    rst_chk("reset_e");
    for (int c = 0; c <= 22; c++) begin
      step(c == 3, 11'd8, (c == 0) || ((c >= 14) && (c <= 21)),
           mk((c >= 3) && (c <= 10), (c >= 4) && (c <= 11), c == 4,
              ((c >= 3) && (c < 21)) ? 2'd1 : 2'd0, (c >= 3) && (c < 21),
              c == 21, (c >= 21) ? 16'd1 : 16'd0, 1'b1),
           "overrun_err", c);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
